// File: rtl/_alu29x03_seq.sv
// rtl/_alu29x03_seq.sv - operation sequencer driving a cascaded _alu29x03 slice datapath
// Single-cycle ALU ops plus a W-iteration shift-add unsigned multiply through the ALU adder.
module _alu29x03_seq #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req,
    output logic         o_ready,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_opa,
    input  logic [W-1:0] i_opb,
    input  logic         i_cin,
    output logic         o_done,
    output logic [W-1:0] o_res_lo,
    output logic [W-1:0] o_res_hi,
    output logic [3:0]   o_flg,
    output logic [W-1:0] o_alu_a,
    output logic [W-1:0] o_alu_b,
    output logic [12:0]  o_alu_ctrl,
    output logic         o_alu_cn,
    input  logic [W-1:0] i_alu_f,
    input  logic         i_alu_cn4,
    input  logic         i_alu_ovr,
    input  logic         i_alu_n
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // ctrl[6:0] = {m,k,j,ben,aen,bpol,apol}
    localparam logic [6:0] C_PASSA = 7'b0000100;
    localparam logic [6:0] C_ADD   = 7'b0101100;
    localparam logic [6:0] C_SUB   = 7'b0101110;
    localparam logic [6:0] C_AND   = 7'b1011100;
    localparam logic [6:0] C_OR    = 7'b0011111;
    localparam logic [6:0] C_XOR   = 7'b0001100;
    localparam logic [6:0] C_CLR   = 7'b0000000;

    logic [1:0]    r_state;
    logic [2:0]    r_op;
    logic [W-1:0]  r_opa;
    logic [W-1:0]  r_opb;
    logic          r_cin;
    logic [W-1:0]  r_h;
    logic [W-1:0]  r_l;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_res_lo;
    logic [W-1:0]  r_res_hi;
    logic [3:0]    r_flg;

    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [6:0]    w_code;
    logic          w_cn;
    logic [W-1:0]  w_h_next;
    logic [W-1:0]  w_l_next;

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_code = C_CLR;
        w_cn   = 1'b0;
        case (r_state)
            S_EXEC: begin
                w_a = r_opa;
                w_b = r_opb;
                case (r_op)
                    3'd0:    w_code = C_PASSA;
                    3'd1:    begin w_code = C_ADD; w_cn = r_cin; end
                    3'd2:    begin w_code = C_SUB; w_cn = r_cin; end
                    3'd3:    w_code = C_AND;
                    3'd4:    w_code = C_OR;
                    3'd5:    w_code = C_XOR;
                    default: w_code = C_CLR;
                endcase
            end
            S_MUL: begin
                // Add the multiplicand into the high half only when the current multiplier bit is set.
                w_a    = r_h;
                w_b    = r_opa;
                w_code = r_l[0] ? C_ADD : C_PASSA;
            end
            default: ;
        endcase
    end

    assign w_h_next = {i_alu_cn4 & r_l[0], i_alu_f[W-1:1]};
    assign w_l_next = {i_alu_f[0], r_l[W-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_op     <= 3'd0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_cin    <= 1'b0;
            r_h      <= '0;
            r_l      <= '0;
            r_cnt    <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_flg    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_op    <= i_op;
                        r_opa   <= i_opa;
                        r_opb   <= i_opb;
                        r_cin   <= i_cin;
                        r_h     <= '0;
                        r_l     <= i_opb;
                        r_cnt   <= '0;
                        r_state <= (i_op == 3'd6) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res_lo <= i_alu_f;
                    r_res_hi <= '0;
                    r_flg    <= {i_alu_cn4, i_alu_ovr, i_alu_n, (i_alu_f == '0)};
                    r_state  <= S_DONE;
                end
                S_MUL: begin
                    r_h   <= w_h_next;
                    r_l   <= w_l_next;
                    r_cnt <= r_cnt + CW'(1);
                    // Only the finished product reaches the result registers.
                    if (r_cnt == CW'(W - 1)) begin
                        r_res_hi <= w_h_next;
                        r_res_lo <= w_l_next;
                        r_flg    <= {2'b00, w_h_next[W-1], ({w_h_next, w_l_next} == '0)};
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_res_lo   = r_res_lo;
    assign o_res_hi   = r_res_hi;
    assign o_flg      = r_flg;
    assign o_alu_a    = w_a;
    assign o_alu_b    = w_b;
    assign o_alu_ctrl = {6'b000000, w_code};
    assign o_alu_cn   = w_cn;
endmodule
